axi_lite_gpio: RTL and testbench
================================

// Module: axi_lite_gpio
// PURPOSE
//   AXI-lite responder (slave) exposing a GPIO register bank with rising-edge interrupts.
//   Sits behind axi_lite_xbar as a new master-port target at 0xa000_1000..0xa000_1fff, next to uart/clint.
//   Decode uses awaddr/araddr[11:0]; the xbar owns base-address matching.
// PARAMETERS
//   GPIO_WIDTH  16  number of GPIO pins (1..32)
// PORTS
//   i_clk     in   1           clock
//   i_rst_n   in   1           async active-low reset
//   awaddr    in   32          write address
//   awvalid   in   1           write address valid
//   awready   out  1           write address ready
//   wdata     in   32          write data
//   wstrb     in   4           write byte strobes
//   wvalid    in   1           write data valid
//   wready    out  1           write data ready
//   bresp     out  2           write response: OKAY=2'b00, SLVERR=2'b10
//   bvalid    out  1           write response valid
//   bready    in   1           write response ready
//   araddr    in   32          read address
//   arvalid   in   1           read address valid
//   arready   out  1           read address ready
//   rdata     out  32          read data
//   rresp     out  2           read response: OKAY/SLVERR
//   rvalid    out  1           read data valid
//   rready    in   1           read data ready
//   i_gpio_in   in   GPIO_WIDTH  asynchronous pin inputs
//   o_gpio_out  out  GPIO_WIDTH  pin output values (OUT reg)
//   o_gpio_oe   out  GPIO_WIDTH  pin output enables (DIR reg, 1=drive)
//   o_irq       out  1           |(IRQ_PEND & IRQ_EN), registered
// BEHAVIOUR
//   Register map (offset[11:0]; bits >= GPIO_WIDTH read 0, writes ignored):
//     0x000 OUT RW | 0x004 IN RO (synced pins) | 0x008 DIR RW | 0x00C IRQ_EN RW | 0x010 IRQ_PEND W1C.
//     Any other offset, or a write to IN -> SLVERR, no state change, rdata=0.
//     Unaligned offset (addr[1:0]!=0) -> SLVERR.
//   Reset (i_rst_n low, async): all registers, sync flops, bvalid, rvalid, o_irq = 0; bresp/rresp/rdata = 0.
//   Write channel (FSM W_IDLE -> W_RESP):
//     AW and W are accepted independently, in any order or in the same cycle.
//     awready = ~aw_held & ~bvalid; wready = ~w_held & ~bvalid.
//     Each channel holds its captured beat until both are present.
//     In the cycle both are held or handshaking: commit the write on that edge, using wstrb per byte.
//     bvalid rises the next cycle (1-cycle latency from the later handshake); state W_RESP.
//     bvalid and bresp are held until bready; then clear aw_held/w_held and return to W_IDLE.
//     Only one outstanding write.
//   Read channel (FSM R_IDLE -> R_RESP):
//     arready = ~rvalid. On AR handshake, register rdata/rresp from current register state.
//     rvalid rises next cycle; rdata/rresp/rvalid held stable until rready; then R_IDLE.
//     Only one outstanding read.
//   Read/write ordering: a read sampled on the same edge a write commits returns the pre-write value.
//   Input sync: i_gpio_in passes through 2 flops (sync1, sync2); IN = sync2.
//     A third flop (prev) gives edge = sync2 & ~prev.
//   IRQ_PEND[i] sets on edge[i] regardless of IRQ_EN.
//     W1C: a written 1 clears the bit, a written 0 keeps it.
//     Set and clear in the same cycle: set wins.
//   o_irq is registered: it reflects PEND/EN one cycle after they change.
//   Reset mid-transaction: aborts immediately. No response is issued after reset release; held beats are discarded.
// TESTING
//   Reset, then read 0x004 with i_gpio_in=16'hA5A5 held 3+ cycles -> rdata=32'h0000A5A5, OKAY, rvalid 1 cycle after AR handshake.
//   W beat (wdata=32'h1234, wstrb=4'b0001) 3 cycles before AW 0x000 -> OUT=16'h0034; bvalid 1 cycle after AW handshake.
//   bready held low 5 cycles -> bvalid/bresp stable, awready=wready=0 throughout.
//   Write 0x014 -> bresp=2'b10, no register changes. Read 0x006 -> rresp=2'b10, rdata=0.
//   IRQ_EN=1, i_gpio_in[0] rises -> IRQ_PEND[0]=1 after 3 cycles, o_irq=1 one cycle later.
//     W1C 0x010 with 32'h1 -> PEND=0, o_irq=0 next cycle.
//     New edge landing in the same cycle as the W1C -> PEND stays 1.
//   Assert i_rst_n low while rvalid=1 and rready=0 -> rvalid=0 immediately; OUT/DIR/IRQ_EN/IRQ_PEND read 0 after release.

Source files
------------

// File: rtl/axi_lite_gpio.sv
// rtl/axi_lite_gpio.sv - AXI-lite GPIO register bank with synchronised inputs and rising-edge interrupts
module axi_lite_gpio #(
    parameter int GPIO_WIDTH = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [31:0]           awaddr,
    input  logic                  awvalid,
    output logic                  awready,
    input  logic [31:0]           wdata,
    input  logic [3:0]            wstrb,
    input  logic                  wvalid,
    output logic                  wready,
    output logic [1:0]            bresp,
    output logic                  bvalid,
    input  logic                  bready,
    input  logic [31:0]           araddr,
    input  logic                  arvalid,
    output logic                  arready,
    output logic [31:0]           rdata,
    output logic [1:0]            rresp,
    output logic                  rvalid,
    input  logic                  rready,
    input  logic [GPIO_WIDTH-1:0] i_gpio_in,
    output logic [GPIO_WIDTH-1:0] o_gpio_out,
    output logic [GPIO_WIDTH-1:0] o_gpio_oe,
    output logic                  o_irq
);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {W_IDLE, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_RESP} r_state_t;

    logic [GPIO_WIDTH-1:0] out_q, dir_q, en_q, pend_q;
    logic [GPIO_WIDTH-1:0] out_d, dir_d, en_d, pend_d, pend_clr;
    logic [GPIO_WIDTH-1:0] sync1_q, sync2_q, prev_q, rise;
    logic                  irq_q;

    w_state_t    w_state_q;
    logic        aw_held_q, w_held_q, bvalid_q;
    logic [11:0] awaddr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic [1:0]  bresp_q;

    r_state_t    r_state_q;
    logic        rvalid_q;
    logic [31:0] rdata_q, rd_data;
    logic [1:0]  rresp_q;
    logic        rd_err;

    logic        aw_hs, w_hs, commit, wr_err;
    logic [11:0] wr_addr;
    logic [31:0] wr_data, byte_mask, wr_val;
    logic [3:0]  wr_strb;
    logic        unused_bits;

    assign awready = ~aw_held_q & ~bvalid_q;
    assign wready  = ~w_held_q & ~bvalid_q;
    assign arready = ~rvalid_q;
    assign bvalid  = bvalid_q;
    assign bresp   = bresp_q;
    assign rvalid  = rvalid_q;
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;
    assign o_gpio_out = out_q;
    assign o_gpio_oe  = dir_q;
    assign o_irq      = irq_q;

    assign aw_hs  = awvalid & awready;
    assign w_hs   = wvalid & wready;
    // A beat captured earlier takes precedence over whatever is on the bus now.
    assign commit = (w_state_q == W_IDLE) & (aw_held_q | aw_hs) & (w_held_q | w_hs);
    assign wr_addr = aw_held_q ? awaddr_q : awaddr[11:0];
    assign wr_data = w_held_q ? wdata_q : wdata;
    assign wr_strb = w_held_q ? wstrb_q : wstrb;
    assign byte_mask = {{8{wr_strb[3]}}, {8{wr_strb[2]}}, {8{wr_strb[1]}}, {8{wr_strb[0]}}};
    assign wr_val  = wr_data & byte_mask;
    assign rise    = sync2_q & ~prev_q;
    assign unused_bits = ^{awaddr[31:12], araddr[31:12], wr_val, byte_mask};

    always_comb begin
        out_d    = out_q;
        dir_d    = dir_q;
        en_d     = en_q;
        pend_clr = '0;
        wr_err   = 1'b1;
        if (commit && wr_addr[1:0] == 2'b00) begin
            case (wr_addr[11:2])
                10'd0: begin out_d = (out_q & ~byte_mask[GPIO_WIDTH-1:0]) | wr_val[GPIO_WIDTH-1:0]; wr_err = 1'b0; end
                10'd2: begin dir_d = (dir_q & ~byte_mask[GPIO_WIDTH-1:0]) | wr_val[GPIO_WIDTH-1:0]; wr_err = 1'b0; end
                10'd3: begin en_d  = (en_q  & ~byte_mask[GPIO_WIDTH-1:0]) | wr_val[GPIO_WIDTH-1:0]; wr_err = 1'b0; end
                10'd4: begin pend_clr = wr_val[GPIO_WIDTH-1:0]; wr_err = 1'b0; end
                default: ;
            endcase
        end
        // A new edge outranks a simultaneous W1C clear.
        pend_d = (pend_q & ~pend_clr) | rise;
    end

    always_comb begin
        rd_data = '0;
        rd_err  = 1'b1;
        if (araddr[1:0] == 2'b00) begin
            case (araddr[11:2])
                10'd0: begin rd_data = 32'(out_q);   rd_err = 1'b0; end
                10'd1: begin rd_data = 32'(sync2_q); rd_err = 1'b0; end
                10'd2: begin rd_data = 32'(dir_q);   rd_err = 1'b0; end
                10'd3: begin rd_data = 32'(en_q);    rd_err = 1'b0; end
                10'd4: begin rd_data = 32'(pend_q);  rd_err = 1'b0; end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            out_q   <= '0;
            dir_q   <= '0;
            en_q    <= '0;
            pend_q  <= '0;
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
            irq_q   <= 1'b0;
        end else begin
            out_q   <= out_d;
            dir_q   <= dir_d;
            en_q    <= en_d;
            pend_q  <= pend_d;
            sync1_q <= i_gpio_in;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            irq_q   <= |(pend_q & en_q);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            w_state_q <= W_IDLE;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
        end else begin
            case (w_state_q)
                W_IDLE: begin
                    if (aw_hs) begin
                        aw_held_q <= 1'b1;
                        awaddr_q  <= awaddr[11:0];
                    end
                    if (w_hs) begin
                        w_held_q <= 1'b1;
                        wdata_q  <= wdata;
                        wstrb_q  <= wstrb;
                    end
                    if (commit) begin
                        bvalid_q  <= 1'b1;
                        bresp_q   <= wr_err ? RESP_SLVERR : RESP_OKAY;
                        w_state_q <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        bvalid_q  <= 1'b0;
                        aw_held_q <= 1'b0;
                        w_held_q  <= 1'b0;
                        w_state_q <= W_IDLE;
                    end
                end
                default: w_state_q <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state_q <= R_IDLE;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            case (r_state_q)
                R_IDLE: begin
                    if (arvalid) begin
                        rvalid_q  <= 1'b1;
                        rdata_q   <= rd_err ? 32'd0 : rd_data;
                        rresp_q   <= rd_err ? RESP_SLVERR : RESP_OKAY;
                        r_state_q <= R_RESP;
                    end
                end
                R_RESP: begin
                    if (rready) begin
                        rvalid_q  <= 1'b0;
                        r_state_q <= R_IDLE;
                    end
                end
                default: r_state_q <= R_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_lite_gpio.sv
// tb/tb_axi_lite_gpio.sv - directed self-checking bench for axi_lite_gpio
module tb_axi_lite_gpio;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] awaddr = '0, wdata = '0, araddr = '0, rdata;
    logic        awvalid = 0, awready, wvalid = 0, wready, bvalid, bready = 0;
    logic        arvalid = 0, arready, rvalid, rready = 0, irq;
    logic [3:0]  wstrb = '0;
    logic [1:0]  bresp, rresp;
    logic [15:0] gpio_in = '0, gpio_out, gpio_oe;
    int          n_tests = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    axi_lite_gpio #(.GPIO_WIDTH(16)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .i_gpio_in(gpio_in), .o_gpio_out(gpio_out), .o_gpio_oe(gpio_oe), .o_irq(irq)
    );

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [1:0] resp);
        int t = 0;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1;
        while (!(awready && wready) && t < 20) begin tick(1); t++; end
        if (t >= 20) begin
            n_tests++; n_fail++;
            $display("FAIL write_ready_timeout addr=%h", a);
        end
        tick(1);
        awvalid = 0; wvalid = 0;
        n_tests++;
        if (bvalid !== 1'b1) begin
            n_fail++; $display("FAIL write_bvalid_latency addr=%h got=%b want=1", a, bvalid);
        end
        resp = bresp;
        bready = 1; tick(1); bready = 0;
    endtask

    task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
        int t = 0;
        araddr = a; arvalid = 1;
        while (!arready && t < 20) begin tick(1); t++; end
        if (t >= 20) begin
            n_tests++; n_fail++;
            $display("FAIL read_ready_timeout addr=%h", a);
        end
        tick(1);
        arvalid = 0;
        n_tests++;
        if (rvalid !== 1'b1) begin
            n_fail++; $display("FAIL read_rvalid_latency addr=%h got=%b want=1", a, rvalid);
        end
        d = rdata; resp = rresp;
        rready = 1; tick(1); rready = 0;
    endtask

    task automatic test_reset();
        n_tests++;
        if ({awready, wready, arready, bvalid, rvalid, irq} !== 6'b111000) begin
            n_fail++; $display("FAIL reset_handshake got=%b want=111000", {awready, wready, arready, bvalid, rvalid, irq});
        end
        n_tests++;
        if ({gpio_out, gpio_oe, rdata, bresp, rresp} !== '0) begin
            n_fail++; $display("FAIL reset_outputs out=%h oe=%h rdata=%h want all 0", gpio_out, gpio_oe, rdata);
        end
    endtask

    task automatic test_read_in();
        logic [31:0] d; logic [1:0] r;
        gpio_in = 16'hA5A5; tick(3);
        do_read(32'h004, d, r);
        n_tests++;
        if (d !== 32'h0000A5A5 || r !== 2'b00) begin
            n_fail++; $display("FAIL read_in got=%h/%b want=0000a5a5/00", d, r);
        end
    endtask

    task automatic test_w_before_aw();
        wdata = 32'h1234; wstrb = 4'b0001; wvalid = 1;
        tick(1); wvalid = 0;
        n_tests++;
        if (wready !== 1'b0 || awready !== 1'b1) begin
            n_fail++; $display("FAIL w_held_ready got w=%b aw=%b want w=0 aw=1", wready, awready);
        end
        tick(3);
        n_tests++;
        if (bvalid !== 1'b0) begin n_fail++; $display("FAIL w_only_no_resp got=%b want=0", bvalid); end
        awaddr = 32'h000; awvalid = 1; tick(1); awvalid = 0;
        n_tests++;
        if (bvalid !== 1'b1 || bresp !== 2'b00 || gpio_out !== 16'h0034) begin
            n_fail++; $display("FAIL w_before_aw got bv=%b br=%b out=%h want 1/00/0034", bvalid, bresp, gpio_out);
        end
        for (int i = 0; i < 5; i++) begin
            tick(1);
            n_tests++;
            if ({bvalid, bresp, awready, wready} !== 5'b10000) begin
                n_fail++; $display("FAIL bready_stall cyc=%0d got=%b want=10000", i, {bvalid, bresp, awready, wready});
            end
        end
        bready = 1; tick(1); bready = 0;
        n_tests++;
        if (bvalid !== 1'b0 || awready !== 1'b1) begin
            n_fail++; $display("FAIL bready_release got bv=%b aw=%b want 0/1", bvalid, awready);
        end
    endtask

    task automatic test_slverr();
        logic [31:0] d; logic [1:0] r;
        do_write(32'h014, 32'hFFFF_FFFF, 4'hF, r);
        n_tests++; if (r !== 2'b10) begin n_fail++; $display("FAIL wr_unmapped bresp=%b want=10", r); end
        do_write(32'h004, 32'hFFFF_FFFF, 4'hF, r);
        n_tests++; if (r !== 2'b10) begin n_fail++; $display("FAIL wr_in bresp=%b want=10", r); end
        do_write(32'h001, 32'hFFFF_FFFF, 4'hF, r);
        n_tests++; if (r !== 2'b10) begin n_fail++; $display("FAIL wr_unaligned bresp=%b want=10", r); end
        do_read(32'h000, d, r);
        n_tests++;
        if (d !== 32'h0000_0034 || r !== 2'b00) begin n_fail++; $display("FAIL slverr_no_change out=%h/%b want=00000034/00", d, r); end
        do_read(32'h00C, d, r);
        n_tests++;
        if (d !== 32'h0) begin n_fail++; $display("FAIL slverr_no_change en=%h want=0", d); end
        do_read(32'h006, d, r);
        n_tests++;
        if (d !== 32'h0 || r !== 2'b10) begin n_fail++; $display("FAIL rd_unaligned got=%h/%b want=0/10", d, r); end
        do_read(32'h800, d, r);
        n_tests++;
        if (d !== 32'h0 || r !== 2'b10) begin n_fail++; $display("FAIL rd_unmapped got=%h/%b want=0/10", d, r); end
    endtask

    task automatic test_strobes_width();
        logic [31:0] d; logic [1:0] r;
        do_write(32'h000, 32'hFFFF_FFFF, 4'hF, r);
        do_read(32'h000, d, r);
        n_tests++;
        if (d !== 32'h0000_FFFF || gpio_out !== 16'hFFFF) begin
            n_fail++; $display("FAIL out_width got=%h pin=%h want=0000ffff/ffff", d, gpio_out);
        end
        do_write(32'h008, 32'h1234_5678, 4'b0010, r);
        do_read(32'h008, d, r);
        n_tests++;
        if (d !== 32'h0000_5600 || gpio_oe !== 16'h5600) begin
            n_fail++; $display("FAIL dir_strobe got=%h oe=%h want=00005600/5600", d, gpio_oe);
        end
    endtask

    task automatic test_irq();
        logic [31:0] d; logic [1:0] r;
        gpio_in = 16'h0000; tick(4);
        do_write(32'h010, 32'hFFFF_FFFF, 4'hF, r);
        do_read(32'h010, d, r);
        n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL pend_clear_all got=%h want=0", d); end
        do_write(32'h00C, 32'h1, 4'hF, r);
        tick(1);
        n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_idle got=%b want=0", irq); end
        gpio_in = 16'h0001;
        tick(3);
        n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_early got=%b want=0", irq); end
        tick(1);
        n_tests++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_rise got=%b want=1", irq); end
        do_read(32'h010, d, r);
        n_tests++; if (d !== 32'h1) begin n_fail++; $display("FAIL pend_set got=%h want=1", d); end
        do_write(32'h010, 32'h1, 4'hF, r);
        n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_after_w1c got=%b want=0", irq); end
        do_read(32'h010, d, r);
        n_tests++; if (d !== 32'h0) begin n_fail++; $display("FAIL pend_w1c got=%h want=0", d); end
        gpio_in = 16'h0000; tick(4);
        gpio_in = 16'h0001; tick(2);
        do_write(32'h010, 32'h1, 4'hF, r);
        do_read(32'h010, d, r);
        n_tests++; if (d !== 32'h1) begin n_fail++; $display("FAIL set_beats_clear got=%h want=1", d); end
        do_write(32'h00C, 32'h0, 4'hF, r);
        n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_masked got=%b want=0", irq); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d; logic [1:0] r;
        awaddr = 32'h000; wdata = 32'h0000_1111; wstrb = 4'hF; araddr = 32'h000;
        awvalid = 1; wvalid = 1; arvalid = 1;
        tick(1);
        awvalid = 0; wvalid = 0; arvalid = 0;
        n_tests++;
        if (rvalid !== 1'b1 || rdata !== 32'h0000_FFFF || bvalid !== 1'b1 || gpio_out !== 16'h1111) begin
            n_fail++; $display("FAIL rw_same_edge got rv=%b rd=%h bv=%b out=%h want 1/0000ffff/1/1111", rvalid, rdata, bvalid, gpio_out);
        end
        rready = 1; bready = 1; tick(1); rready = 0; bready = 0;
        do_read(32'h000, d, r);
        n_tests++; if (d !== 32'h0000_1111) begin n_fail++; $display("FAIL rw_after got=%h want=00001111", d); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d; logic [1:0] r;
        gpio_in = 16'h0000; tick(4);
        wdata = 32'hFFFF; wstrb = 4'hF; wvalid = 1; tick(1); wvalid = 0;
        araddr = 32'h000; arvalid = 1; tick(1); arvalid = 0;
        n_tests++; if (rvalid !== 1'b1) begin n_fail++; $display("FAIL pre_reset_rvalid got=%b want=1", rvalid); end
        #1 rst_n = 0;
        #1;
        n_tests++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL async_reset_rvalid got=%b want=0", rvalid); end
        tick(2);
        #2 rst_n = 1;
        tick(3);
        n_tests++;
        if (bvalid !== 1'b0 || rvalid !== 1'b0 || wready !== 1'b1) begin
            n_fail++; $display("FAIL post_reset_idle got bv=%b rv=%b wr=%b want 0/0/1", bvalid, rvalid, wready);
        end
        for (int i = 0; i < 4; i++) begin
            logic [31:0] a;
            a = (i == 0) ? 32'h000 : (i == 1) ? 32'h008 : (i == 2) ? 32'h00C : 32'h010;
            do_read(a, d, r);
            n_tests++;
            if (d !== 32'h0 || r !== 2'b00) begin n_fail++; $display("FAIL post_reset_reg addr=%h got=%h/%b want=0/00", a, d, r); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        tick(3);
        test_reset();
        rst_n = 1;
        tick(1);
        test_read_in();
        test_w_before_aw();
        test_slverr();
        test_strobes_width();
        test_irq();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
